reg_scoreboard: RTL and testbench

- Parametrised register-reservation scoreboard between the decode and execute stages.
- Generalises the single global "reserved" flag into per-register pending-write counters, so several writes can be outstanding at once.
- Accepts up to NUM_WB writeback retirements per cycle.
- Produces the RAW/WAW stall to decode, with optional same-cycle writeback bypass.

---
 rtl/reg_scoreboard.sv | 155 +++++++++++++++
 tb/tb_reg_scoreboard.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Register-reservation scoreboard sitting between decode and
//               execute. Each architectural register has a small pending-write
//               counter, so several writes to the same or different registers
//               may be in flight at once. Up to NUM_WB writebacks retire per
//               cycle. The block produces the RAW / WAW-saturation stall seen
//               by decode, optionally letting a same-cycle writeback unblock a
//               dependent reader.
//
// Ports       : clk               clock
//               rst               asynchronous active-high reset
//               issue_valid_i     decode presents an instruction
//               issue_rd_regno_i  destination / first-source register
//               issue_rs_regno_i  second-source register
//               issue_rd_read_i   instruction reads rd
//               issue_rs_read_i   instruction reads rs
//               issue_writes_i    instruction writes rd
//               stall_o           (comb) instruction must not issue
//               accept_o          (comb) issue_valid_i & !stall_o
//               wb_valid_i        per-port retire strobe
//               wb_regno_i        per-port retired register number
//               busy_o            (reg) bit r set when counter[r] != 0
//               outstanding_o     (reg) sum of all pending counters
//               err_o             (reg, sticky) counter underflow seen
//
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
  parameter int LEN_REGNO = 4,
  parameter int NUM_WB    = 1,
  parameter int CNT_W     = 2,
  parameter int BYPASS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_valid_i,
  input  logic [LEN_REGNO-1:0]          issue_rd_regno_i,
  input  logic [LEN_REGNO-1:0]          issue_rs_regno_i,
  input  logic                          issue_rd_read_i,
  input  logic                          issue_rs_read_i,
  input  logic                          issue_writes_i,
  output logic                          stall_o,
  output logic                          accept_o,
  input  logic [NUM_WB-1:0]             wb_valid_i,
  input  logic [NUM_WB*LEN_REGNO-1:0]   wb_regno_i,
  output logic [(2**LEN_REGNO)-1:0]     busy_o,
  output logic [LEN_REGNO+CNT_W-1:0]    outstanding_o,
  output logic                          err_o
);

  localparam int c_NUM_REGS = 2 ** LEN_REGNO;
  // Up to four retire ports can hit one register, so three bits hold the count.
  localparam int c_DEC_W    = 3;
  localparam int c_EXT_W    = (CNT_W > c_DEC_W) ? CNT_W : c_DEC_W;
  localparam int c_SUM_W    = LEN_REGNO + CNT_W;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // State
  logic [CNT_W-1:0]      r_cnt [c_NUM_REGS];
  logic [c_NUM_REGS-1:0] r_busy;
  logic [c_SUM_W-1:0]    r_outstanding;
  logic                  r_err;

  // Per-register combinational terms
  logic [c_DEC_W-1:0]    w_dec  [c_NUM_REGS];
  logic [c_NUM_REGS-1:0] w_under;
  logic [CNT_W-1:0]      w_post [c_NUM_REGS];
  logic [CNT_W-1:0]      w_pend [c_NUM_REGS];
  logic [CNT_W-1:0]      w_next [c_NUM_REGS];
  logic [c_NUM_REGS-1:0] w_busy_next;
  logic [c_SUM_W-1:0]    w_sum_next;

  logic                  w_raw;
  logic                  w_sat;
  logic                  w_stall;
  logic                  w_accept;

  // --------------------------------------------------------------------------
  // Retire decrement and post-retire counter value per register.
  // A retire exceeding the pending count clamps the counter at zero and is
  // flagged through w_under; it never borrows from neighbouring registers.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < c_NUM_REGS; r++) begin
      w_dec[r] = '0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid_i[k] && (wb_regno_i[k*LEN_REGNO +: LEN_REGNO] == LEN_REGNO'(r))) begin
          w_dec[r] = w_dec[r] + c_DEC_W'(1);
        end
      end
      w_under[r] = c_EXT_W'(w_dec[r]) > c_EXT_W'(r_cnt[r]);
      w_post[r]  = w_under[r] ? {CNT_W{1'b0}} : (r_cnt[r] - CNT_W'(w_dec[r]));
      // Without bypass a reader only sees the registered count, so a
      // retire releases it one cycle later.
      w_pend[r]  = (BYPASS != 0) ? w_post[r] : r_cnt[r];
    end
  end

  // --------------------------------------------------------------------------
  // Hazard detection. Saturation always looks at the post-retire count so a
  // write may take the slot a same-cycle retire is freeing, bypass or not.
  // --------------------------------------------------------------------------
  always_comb begin
    w_raw    = (issue_rd_read_i && (w_pend[issue_rd_regno_i] != {CNT_W{1'b0}})) ||
               (issue_rs_read_i && (w_pend[issue_rs_regno_i] != {CNT_W{1'b0}}));
    w_sat    = issue_writes_i && (w_post[issue_rd_regno_i] == c_CNT_MAX);
    w_stall  = issue_valid_i && (w_raw || w_sat);
    w_accept = issue_valid_i && !w_stall;
  end

  // --------------------------------------------------------------------------
  // Next counter values and the registered summary outputs derived from them.
  // An accepted write cannot overflow: saturation blocks it at c_CNT_MAX.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sum_next = '0;
    for (int r = 0; r < c_NUM_REGS; r++) begin
      w_next[r]      = w_post[r] +
                       ((w_accept && issue_writes_i && (issue_rd_regno_i == LEN_REGNO'(r)))
                        ? CNT_W'(1) : {CNT_W{1'b0}});
      w_busy_next[r] = (w_next[r] != {CNT_W{1'b0}});
      w_sum_next     = w_sum_next + c_SUM_W'(w_next[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < c_NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
      r_busy        <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      for (int r = 0; r < c_NUM_REGS; r++) begin
        r_cnt[r] <= w_next[r];
      end
      r_busy        <= w_busy_next;
      r_outstanding <= w_sum_next;
      if (|w_under) begin
        r_err <= 1'b1;
      end
    end
  end

  assign stall_o       = w_stall;
  assign accept_o      = w_accept;
  assign busy_o        = r_busy;
  assign outstanding_o = r_outstanding;
  assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Self-checking bench for reg_scoreboard. Stimulus pushes the
//               hand-computed expected output values into a queue tagged with
//               the cycle they apply to; a monitor drains the queue on the
//               falling edge and compares against the DUT outputs.
//               dut_a : NUM_WB=2, BYPASS=1; dut_b : NUM_WB=1, BYPASS=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

  localparam int S_A_STALL  = 0;
  localparam int S_A_ACCEPT = 1;
  localparam int S_A_BUSY   = 2;
  localparam int S_A_OUT    = 3;
  localparam int S_A_ERR    = 4;
  localparam int S_B_STALL  = 5;
  localparam int S_B_ACCEPT = 6;
  localparam int S_B_BUSY   = 7;
  localparam int S_B_OUT    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut_a signals
  logic        a_valid, a_rd_read, a_rs_read, a_writes;
  logic [3:0]  a_rd, a_rs;
  logic        a_stall, a_accept;
  logic [1:0]  a_wb_valid;
  logic [7:0]  a_wb_regno;
  logic [15:0] a_busy;
  logic [5:0]  a_out;
  logic        a_err;

  // dut_b signals
  logic        b_valid, b_rd_read, b_rs_read, b_writes;
  logic [3:0]  b_rd, b_rs;
  logic        b_stall, b_accept;
  logic [0:0]  b_wb_valid;
  logic [3:0]  b_wb_regno;
  logic [15:0] b_busy;
  logic [5:0]  b_out;
  logic        b_err;

  reg_scoreboard #(.LEN_REGNO(4), .NUM_WB(2), .CNT_W(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst),
    .issue_valid_i(a_valid), .issue_rd_regno_i(a_rd), .issue_rs_regno_i(a_rs),
    .issue_rd_read_i(a_rd_read), .issue_rs_read_i(a_rs_read), .issue_writes_i(a_writes),
    .stall_o(a_stall), .accept_o(a_accept),
    .wb_valid_i(a_wb_valid), .wb_regno_i(a_wb_regno),
    .busy_o(a_busy), .outstanding_o(a_out), .err_o(a_err)
  );

  reg_scoreboard #(.LEN_REGNO(4), .NUM_WB(1), .CNT_W(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst),
    .issue_valid_i(b_valid), .issue_rd_regno_i(b_rd), .issue_rs_regno_i(b_rs),
    .issue_rd_read_i(b_rd_read), .issue_rs_read_i(b_rs_read), .issue_writes_i(b_writes),
    .stall_o(b_stall), .accept_o(b_accept),
    .wb_valid_i(b_wb_valid), .wb_regno_i(b_wb_regno),
    .busy_o(b_busy), .outstanding_o(b_out), .err_o(b_err)
  );

  // Expectation queue (parallel queues: cycle, signal selector, value)
  int          q_cyc[$];
  int          q_sel[$];
  logic [31:0] q_val[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic string sel_name(int sel);
    case (sel)
      S_A_STALL:  return "a.stall";
      S_A_ACCEPT: return "a.accept";
      S_A_BUSY:   return "a.busy";
      S_A_OUT:    return "a.outstanding";
      S_A_ERR:    return "a.err";
      S_B_STALL:  return "b.stall";
      S_B_ACCEPT: return "b.accept";
      S_B_BUSY:   return "b.busy";
      S_B_OUT:    return "b.outstanding";
      default:    return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] actual(int sel);
    case (sel)
      S_A_STALL:  return 32'(a_stall);
      S_A_ACCEPT: return 32'(a_accept);
      S_A_BUSY:   return 32'(a_busy);
      S_A_OUT:    return 32'(a_out);
      S_A_ERR:    return 32'(a_err);
      S_B_STALL:  return 32'(b_stall);
      S_B_ACCEPT: return 32'(b_accept);
      S_B_BUSY:   return 32'(b_busy);
      S_B_OUT:    return 32'(b_out);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare everything expected for the current cycle.
  initial begin
    int          c;
    int          s;
    logic [31:0] v;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
        c = q_cyc.pop_front();
        s = q_sel.pop_front();
        v = q_val.pop_front();
        act = actual(s);
        n_cmp++;
        if (c != cyc || act !== v) begin
          n_bad++;
          $display("FAIL %s (cycle %0d, checked %0d): actual=%0h required=%0h",
                   sel_name(s), c, cyc, act, v);
        end
      end
    end
  end

  task automatic idle_inputs();
    a_valid = 1'b0; a_rd = 4'd0; a_rs = 4'd0;
    a_rd_read = 1'b0; a_rs_read = 1'b0; a_writes = 1'b0;
    a_wb_valid = 2'b00; a_wb_regno = 8'h00;
    b_valid = 1'b0; b_rd = 4'd0; b_rs = 4'd0;
    b_rd_read = 1'b0; b_rs_read = 1'b0; b_writes = 1'b0;
    b_wb_valid = 1'b0; b_wb_regno = 4'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic expect_val(int sel, logic [31:0] v);
    q_cyc.push_back(cyc);
    q_sel.push_back(sel);
    q_val.push_back(v);
  endtask

  task automatic issue_a(logic [3:0] rd, logic [3:0] rs, logic rdr, logic rsr, logic wr);
    a_valid = 1'b1; a_rd = rd; a_rs = rs;
    a_rd_read = rdr; a_rs_read = rsr; a_writes = wr;
  endtask

  task automatic issue_b(logic [3:0] rd, logic [3:0] rs, logic rdr, logic rsr, logic wr);
    b_valid = 1'b1; b_rd = rd; b_rs = rs;
    b_rd_read = rdr; b_rs_read = rsr; b_writes = wr;
  endtask

  task automatic wb_a(logic [1:0] v, logic [3:0] r0, logic [3:0] r1);
    a_wb_valid = v;
    a_wb_regno = {r1, r0};
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset then idle
    expect_val(S_A_STALL, 0);  expect_val(S_A_ACCEPT, 0);
    expect_val(S_A_BUSY, 0);   expect_val(S_A_OUT, 0);  expect_val(S_A_ERR, 0);
    expect_val(S_B_STALL, 0);  expect_val(S_B_BUSY, 0);

    // Reader of r3 with nothing pending is accepted
    next_cycle(); issue_a(4'd3, 4'd3, 1'b1, 1'b1, 1'b0);
    expect_val(S_A_STALL, 0);  expect_val(S_A_ACCEPT, 1);

    // Basic RAW on r3 with bypass release
    next_cycle(); issue_a(4'd3, 4'd0, 1'b0, 1'b0, 1'b1);
    expect_val(S_A_ACCEPT, 1); expect_val(S_A_BUSY, 0);
    next_cycle(); issue_a(4'd0, 4'd3, 1'b0, 1'b1, 1'b0);
    expect_val(S_A_STALL, 1);  expect_val(S_A_ACCEPT, 0);
    expect_val(S_A_BUSY, 16'h0008); expect_val(S_A_OUT, 1);
    next_cycle(); issue_a(4'd0, 4'd3, 1'b0, 1'b1, 1'b0); wb_a(2'b01, 4'd3, 4'd0);
    expect_val(S_A_STALL, 0);  expect_val(S_A_ACCEPT, 1);
    expect_val(S_A_BUSY, 16'h0008);
    next_cycle();
    expect_val(S_A_BUSY, 0);   expect_val(S_A_OUT, 0);

    // Saturation on r5
    next_cycle(); issue_a(4'd5, 4'd0, 1'b0, 1'b0, 1'b1);
    expect_val(S_A_ACCEPT, 1);
    next_cycle(); issue_a(4'd5, 4'd0, 1'b0, 1'b0, 1'b1);
    expect_val(S_A_ACCEPT, 1); expect_val(S_A_OUT, 1);
    next_cycle(); issue_a(4'd5, 4'd0, 1'b0, 1'b0, 1'b1);
    expect_val(S_A_ACCEPT, 1); expect_val(S_A_OUT, 2);
    next_cycle(); issue_a(4'd5, 4'd0, 1'b0, 1'b0, 1'b1);
    expect_val(S_A_STALL, 1);  expect_val(S_A_OUT, 3);  expect_val(S_A_BUSY, 16'h0020);
    next_cycle(); issue_a(4'd5, 4'd0, 1'b0, 1'b0, 1'b1); wb_a(2'b01, 4'd5, 4'd0);
    expect_val(S_A_STALL, 0);  expect_val(S_A_ACCEPT, 1);
    next_cycle(); wb_a(2'b11, 4'd5, 4'd5);
    expect_val(S_A_OUT, 3);    expect_val(S_A_BUSY, 16'h0020);
    next_cycle(); wb_a(2'b01, 4'd5, 4'd0);
    expect_val(S_A_OUT, 1);
    next_cycle();
    expect_val(S_A_OUT, 0);    expect_val(S_A_BUSY, 0);  expect_val(S_A_ERR, 0);

    // Dual retire of r7 with a bypassed reader
    next_cycle(); issue_a(4'd7, 4'd0, 1'b0, 1'b0, 1'b1);
    next_cycle(); issue_a(4'd7, 4'd0, 1'b0, 1'b0, 1'b1);
    expect_val(S_A_OUT, 1);
    next_cycle(); issue_a(4'd7, 4'd0, 1'b1, 1'b0, 1'b0); wb_a(2'b11, 4'd7, 4'd7);
    expect_val(S_A_OUT, 2);    expect_val(S_A_BUSY, 16'h0080);
    expect_val(S_A_STALL, 0);  expect_val(S_A_ACCEPT, 1);
    next_cycle();
    expect_val(S_A_OUT, 0);    expect_val(S_A_BUSY, 0);  expect_val(S_A_ERR, 0);

    // rd == rs, hazard only through the read flags; retire via port 1
    next_cycle(); issue_a(4'd1, 4'd0, 1'b0, 1'b0, 1'b1);
    next_cycle(); issue_a(4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    expect_val(S_A_STALL, 0);  expect_val(S_A_BUSY, 16'h0002);
    next_cycle(); issue_a(4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
    expect_val(S_A_STALL, 1);  expect_val(S_A_ACCEPT, 0);
    next_cycle(); wb_a(2'b10, 4'd0, 4'd1);
    expect_val(S_A_STALL, 0);
    next_cycle();
    expect_val(S_A_BUSY, 0);

    // Underflow on r9 alongside a write to r4
    next_cycle(); wb_a(2'b01, 4'd9, 4'd0); issue_a(4'd4, 4'd0, 1'b0, 1'b0, 1'b1);
    expect_val(S_A_ACCEPT, 1); expect_val(S_A_ERR, 0);
    next_cycle();
    expect_val(S_A_ERR, 1);    expect_val(S_A_BUSY, 16'h0010);  expect_val(S_A_OUT, 1);
    next_cycle(); wb_a(2'b01, 4'd4, 4'd0);
    expect_val(S_A_ERR, 1);
    next_cycle();
    expect_val(S_A_ERR, 1);    expect_val(S_A_BUSY, 0);  expect_val(S_A_OUT, 0);

    // Async reset between edges with r6 pending
    next_cycle(); issue_a(4'd6, 4'd0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    expect_val(S_A_BUSY, 16'h0040);
    next_cycle();
    rst = 1'b1;
    expect_val(S_A_BUSY, 0);   expect_val(S_A_OUT, 0);  expect_val(S_A_ERR, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // BYPASS=0: retire releases the reader one cycle later
    next_cycle(); issue_b(4'd2, 4'd0, 1'b0, 1'b0, 1'b1);
    expect_val(S_B_ACCEPT, 1); expect_val(S_B_BUSY, 0);
    next_cycle(); issue_b(4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
    expect_val(S_B_STALL, 1);  expect_val(S_B_BUSY, 16'h0004);  expect_val(S_B_OUT, 1);
    next_cycle(); issue_b(4'd2, 4'd0, 1'b1, 1'b0, 1'b0); b_wb_valid = 1'b1; b_wb_regno = 4'd2;
    expect_val(S_B_STALL, 1);  expect_val(S_B_ACCEPT, 0);
    next_cycle(); issue_b(4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
    expect_val(S_B_STALL, 0);  expect_val(S_B_ACCEPT, 1);
    expect_val(S_B_BUSY, 0);   expect_val(S_B_OUT, 0);

    next_cycle();
    repeat (2) @(posedge clk);
    if (q_cyc.size() != 0) begin
      n_bad += q_cyc.size();
      $display("FAIL drain: actual=%0d pending expectations, required=0", q_cyc.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
